// File: rtl/if_fetch_stage_if.sv
// Instruction-memory read bus between the fetch stage and instruction memory.
//   imem_req   : read request, held until imem_ready
//   imem_addr  : read address, stable while imem_req=1 until imem_ready
//   imem_ready : read data valid this cycle (meaningful only while imem_req=1)
//   imem_rdata : instruction word returned by memory
// master = fetch stage, slave = instruction memory.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register.
// Owns the fetch PC, issues req/ready reads to a variable-latency instruction memory,
// freezes on hazards, flushes/redirects on branch_taken and parks one instruction in a
// skid buffer when it returns while ID is frozen.
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-low reset
//   freeze        : hazard stall; IF/ID register and fetch PC hold
//   branch_taken  : redirect/flush request from EXE, target on branch_addr
//   imem          : instruction-memory bus (master side)
//   if_valid      : IF/ID holds a real instruction
//   pc_out        : IF/ID PC = fetch address + PC_STEP
//   inst_out      : IF/ID instruction
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_addr,
  if_fetch_stage_if.master       imem,
  output logic                   if_valid,
  output logic [31:0]            pc_out,
  output logic [31:0]            inst_out
);

  // StFetch  : request outstanding on fetch_pc
  // StHold   : a word was parked in the skid buffer while ID was frozen; no request
  // StDiscard: a redirect arrived while a read was outstanding; finish and drop that read
  typedef enum logic [1:0] {
    StFetch   = 2'd0,
    StHold    = 2'd1,
    StDiscard = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] redirect_q, redirect_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] inst_out_q, inst_out_d;

  logic [31:0] pc_next;

  // 32-bit modulo increment; the top word wraps to address 0.
  assign pc_next = fetch_pc_q + PC_STEP;

  assign imem.imem_req  = (state_q == StFetch) || (state_q == StDiscard);
  assign imem.imem_addr = fetch_pc_q;

  assign if_valid = if_valid_q;
  assign pc_out   = pc_out_q;
  assign inst_out = inst_out_q;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    redirect_d  = redirect_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    if_valid_d  = if_valid_q;
    pc_out_d    = pc_out_q;
    inst_out_d  = inst_out_q;

    case (state_q)
      StFetch: begin
        if (branch_taken) begin
          if_valid_d = 1'b0;
          inst_out_d = NOP_INST;
          if (imem.imem_ready) begin
            fetch_pc_d = branch_addr;
          end else begin
            // Keep fetch_pc so the outstanding address stays stable until it completes.
            redirect_d = branch_addr;
            state_d    = StDiscard;
          end
        end else if (imem.imem_ready) begin
          fetch_pc_d = pc_next;
          if (freeze) begin
            skid_pc_d   = pc_next;
            skid_inst_d = imem.imem_rdata;
            state_d     = StHold;
          end else begin
            if_valid_d = 1'b1;
            pc_out_d   = pc_next;
            inst_out_d = imem.imem_rdata;
          end
        end else if (!freeze) begin
          if_valid_d = 1'b0;
        end
      end

      StHold: begin
        if (branch_taken) begin
          fetch_pc_d = branch_addr;
          if_valid_d = 1'b0;
          inst_out_d = NOP_INST;
          state_d    = StFetch;
        end else if (!freeze) begin
          if_valid_d = 1'b1;
          pc_out_d   = skid_pc_q;
          inst_out_d = skid_inst_q;
          state_d    = StFetch;
        end
      end

      StDiscard: begin
        // The latest redirect wins, including one arriving with the dropped data.
        if (imem.imem_ready) begin
          fetch_pc_d = branch_taken ? branch_addr : redirect_q;
          state_d    = StFetch;
        end else if (branch_taken) begin
          redirect_d = branch_addr;
        end
      end

      default: begin
        state_d = StFetch;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StFetch;
      fetch_pc_q  <= RESET_PC;
      redirect_q  <= 32'h0;
      skid_pc_q   <= 32'h0;
      skid_inst_q <= 32'h0;
      if_valid_q  <= 1'b0;
      pc_out_q    <= 32'h0;
      inst_out_q  <= NOP_INST;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      redirect_q  <= redirect_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      if_valid_q  <= if_valid_d;
      pc_out_q    <= pc_out_d;
      inst_out_q  <= inst_out_d;
    end
  end

endmodule
